// File: rtl/vga_timing.sv
// vga_timing
//   Raster timing generator and VGA output stage for 640x480@60 on the Nexys3.
//   Free-running h_count/v_count go out to the drawing stage. Its RGB332 pixel
//   comes back PIPE_DELAY cycles later. hs/vs/vis are delayed by the same amount,
//   so the pins stay aligned, and are then registered once more at the output.
//
// Ports
//   clk_25       25 MHz pixel clock
//   rst_n        async active-low reset
//   h_count      column 0..H_TOTAL-1 (registered)
//   v_count      line   0..V_TOTAL-1 (registered)
//   frame_start  high exactly while the counts read (0,0)
//   rgb_in       RGB332 pixel from the drawing stage {R[7:5],G[4:2],B[1:0]}
//   test_mode    selects internal colour bars (only with VGA_TEST_PATTERN_EN)
//   hsync/vsync  active-low syncs
//   vga_red/vga_green/vga_blue  blanked pixel to the pins
//
// Build option
//   VGA_TEST_PATTERN_EN  builds the 8-bar test pattern; otherwise test_mode is ignored.
module vga_timing #(
  parameter int PIPE_DELAY = 1,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525
) (
  input  logic       clk_25,
  input  logic       rst_n,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       frame_start,
  input  logic [7:0] rgb_in,
  input  logic       test_mode,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue
);

  // Delay-line tap: {bar, vis, vs, hs}. The bar index only exists with the pattern.
`ifdef VGA_TEST_PATTERN_EN
  localparam int TW = 6;
`else
  localparam int TW = 3;
`endif
  // Idle tap: syncs inactive (high), blanked, bar 0.
  localparam logic [TW-1:0] TAP_IDLE = TW'(3);

  // ---------------- counters ----------------
  logic       h_last, v_last;
  logic [9:0] h_nxt, v_nxt;

  always_comb begin
    h_last = (h_count == 10'(H_TOTAL - 1));
    v_last = (v_count == 10'(V_TOTAL - 1));
    h_nxt  = h_last ? 10'd0 : h_count + 10'd1;
    v_nxt  = h_last ? (v_last ? 10'd0 : v_count + 10'd1) : v_count;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_count     <= 10'd0;
      v_count     <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      // Flag is computed from the next counts, so it is high alongside (0,0).
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  // ---------------- raw decode ----------------
  logic          hs_raw, vs_raw, vis_raw;
  logic [TW-1:0] tap_raw, tap_d;

  always_comb begin
    hs_raw  = (h_count >= 10'd96);
    vs_raw  = (v_count >= 10'd2);
    vis_raw = (h_count >= 10'd144) && (h_count < 10'd784) &&
              (v_count >= 10'd35)  && (v_count < 10'd515);
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] hx;
  logic [2:0] bar_raw;
  always_comb begin
    hx      = h_count - 10'd144;
    // Only meaningful inside the visible window; blanked elsewhere.
    bar_raw = 3'(hx / 10'd80);
    tap_raw = {bar_raw, vis_raw, vs_raw, hs_raw};
  end
`else
  assign tap_raw = {vis_raw, vs_raw, hs_raw};
`endif

  // ---------------- PIPE_DELAY-deep delay line ----------------
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign tap_d = tap_raw;
    end else begin : g_dly
      logic [TW-1:0] sr [PIPE_DELAY];
      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= TAP_IDLE;
        end else begin
          sr[0] <= tap_raw;
          for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
        end
      end
      assign tap_d = sr[PIPE_DELAY-1];
    end
  endgenerate

  // ---------------- pixel source select ----------------
  logic [7:0] px_src;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_d;
  always_comb begin
    bar_d  = tap_d[5:3];
    px_src = test_mode ? {{3{bar_d[2]}}, {3{bar_d[1]}}, {2{bar_d[0]}}} : rgb_in;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign px_src = rgb_in;
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hsync                          <= 1'b1;
      vsync                          <= 1'b1;
      {vga_red, vga_green, vga_blue} <= 8'h00;
    end else begin
      hsync                          <= tap_d[0];
      vsync                          <= tap_d[1];
      {vga_red, vga_green, vga_blue} <= tap_d[2] ? px_src : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing. Built with PIPE_DELAY=2 and a shortened
// frame (V_TOTAL=38), so several frames fit in a short run. The stimulus
// pushes one expected output bundle per cycle, built from the cycle count
// since reset release. A negedge monitor pops and compares each bundle, plus
// a list of hand-computed spot values keyed by cycle.
module tb_vga_timing;
  localparam int PD = 2;
  localparam int HT = 800;
  localparam int VT = 38;

  logic       clk_25 = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count;
  logic       frame_start;
  logic [7:0] rgb_in;
  logic       test_mode;
  logic       hsync, vsync;
  logic [2:0] vga_red, vga_green;
  logic [1:0] vga_blue;

  vga_timing #(.PIPE_DELAY(PD), .H_TOTAL(HT), .V_TOTAL(VT)) dut (
    .clk_25(clk_25), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .frame_start(frame_start), .rgb_in(rgb_in), .test_mode(test_mode),
    .hsync(hsync), .vsync(vsync), .vga_red(vga_red), .vga_green(vga_green),
    .vga_blue(vga_blue)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [7:0] px;
  } exp_t;

  typedef struct {
    int at;
    int sel;
    int val;
  } spot_t;

  localparam int S_H = 0, S_V = 1, S_FS = 2, S_HS = 3, S_VS = 4, S_PX = 5;

  exp_t  sbq [$];
  spot_t dq  [$];
  int    cyc = 0;
  int    mrun = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  // Reference: outputs for a cycle that is r edges past reset release, with the
  // pixel inputs that were held during the previous cycle.
  function automatic exp_t model(input int r, input logic [7:0] prgb, input logic ptm);
    exp_t e;
    int   ch, cv, sr, ph, pv;
    logic [2:0] k;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    ch   = r % HT;
    cv   = (r / HT) % VT;
    e.h  = 10'(ch);
    e.v  = 10'(cv);
    e.fs = (r > 0) && (ch == 0) && (cv == 0);
    if (r >= PD + 1) begin
      sr   = r - PD - 1;
      ph   = sr % HT;
      pv   = (sr / HT) % VT;
      e.hs = (ph >= 96);
      e.vs = (pv >= 2);
      if (ph >= 144 && ph < 784 && pv >= 35 && pv < 515) begin
        e.px = prgb;
`ifdef VGA_TEST_PATTERN_EN
        if (ptm) begin
          k    = 3'((ph - 144) / 80);
          e.px = {{3{k[2]}}, {3{k[1]}}, {2{k[0]}}};
        end
`endif
      end
    end
    if (ptm === 1'bx) e.px = e.px; // test_mode is always driven; kept total for X-safety
    return e;
  endfunction

  task automatic tick(input logic r, input logic [7:0] rgb, input logic tm);
    logic [7:0] prgb;
    logic       ptm;
    @(posedge clk_25);
    #1;
    cyc++;
    if (rst_n) mrun++;
    else       mrun = 0;
    prgb      = rgb_in;
    ptm       = test_mode;
    rst_n     = r;
    rgb_in    = rgb;
    test_mode = tm;
    if (!r) mrun = 0;
    sbq.push_back(model(mrun, prgb, ptm));
  endtask

  task automatic want(input int at, input int sel, input int val);
    spot_t s;
    s.at = at; s.sel = sel; s.val = val;
    dq.push_back(s);
  endtask

  function automatic string sname(input int sel);
    case (sel)
      S_H:  return "h_count";
      S_V:  return "v_count";
      S_FS: return "frame_start";
      S_HS: return "hsync";
      S_VS: return "vsync";
      default: return "pixel";
    endcase
  endfunction

  function automatic int pick(input int sel);
    case (sel)
      S_H:  return int'(h_count);
      S_V:  return int'(v_count);
      S_FS: return int'(frame_start);
      S_HS: return int'(hsync);
      S_VS: return int'(vsync);
      default: return int'({vga_red, vga_green, vga_blue});
    endcase
  endfunction

  // Monitor: one bundle per cycle, plus any spot values due this cycle.
  always @(negedge clk_25) begin
    exp_t e, a;
    int   act;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {h_count, v_count, frame_start, hsync, vsync, vga_red, vga_green, vga_blue};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL bundle cyc=%0d got h=%0d v=%0d fs=%0b hs=%0b vs=%0b px=%02h want h=%0d v=%0d fs=%0b hs=%0b vs=%0b px=%02h",
                    cyc, a.h, a.v, a.fs, a.hs, a.vs, a.px, e.h, e.v, e.fs, e.hs, e.vs, e.px);
    end
    for (int i = dq.size() - 1; i >= 0; i--) begin
      if (dq[i].at == cyc) begin
        act = pick(dq[i].sel);
        n_chk++;
        if (act == dq[i].val) n_pass++;
        else $display("FAIL spot %s cyc=%0d got %0h want %0h", sname(dq[i].sel), cyc, act, dq[i].val);
        dq.delete(i);
      end
    end
  end

  initial begin
    int rel0, rmid, rel1;
    rst_n     = 1'b0;
    rgb_in    = 8'hCE;
    test_mode = 1'b0;

    // Reset held for 5 clocks; bundle checks cover the reset values.
    repeat (5) tick(1'b0, 8'hCE, 1'b0);
    tick(1'b1, 8'hCE, 1'b0);
    rel0 = cyc;

    // Hand-computed spot values (PIPE_DELAY=2, 800x38 raster).
    want(rel0 + 1,     S_H, 1);
    want(rel0 + 2,     S_HS, 1);
    want(rel0 + 3,     S_HS, 0);
    want(rel0 + 98,    S_HS, 0);
    want(rel0 + 99,    S_HS, 1);
    want(rel0 + 799,   S_H, 799);
    want(rel0 + 800,   S_H, 0);
    want(rel0 + 800,   S_V, 1);
    want(rel0 + 1602,  S_VS, 0);
    want(rel0 + 1603,  S_VS, 1);
    want(rel0 + 28146, S_PX, 8'h00);
    want(rel0 + 28147, S_PX, 8'hCE);
    want(rel0 + 28786, S_PX, 8'hCE);
    want(rel0 + 28787, S_PX, 8'h00);
    want(rel0 + 30399, S_H, 799);
    want(rel0 + 30399, S_V, 37);
    want(rel0 + 30399, S_FS, 0);
    want(rel0 + 30400, S_H, 0);
    want(rel0 + 30400, S_V, 0);
    want(rel0 + 30400, S_FS, 1);
    want(rel0 + 30401, S_FS, 0);
    want(rel0 + 30402, S_VS, 1);
    want(rel0 + 30403, S_VS, 0);
    want(rel0 + 30403, S_HS, 0);
    want(rel0 + 32002, S_VS, 0);
    want(rel0 + 32003, S_VS, 1);
    want(rel0 + 58546, S_PX, 8'h00);
    want(rel0 + 59187, S_PX, 8'h00);
`ifdef VGA_TEST_PATTERN_EN
    want(rel0 + 58547, S_PX, 8'h00);
    want(rel0 + 58626, S_PX, 8'h00);
    want(rel0 + 58627, S_PX, 8'h03);
    want(rel0 + 59107, S_PX, 8'hFF);
    want(rel0 + 59186, S_PX, 8'hFF);
`endif

    // Frame 1: constant pixel.
    while (mrun < 30399) tick(1'b1, 8'hCE, 1'b0);
    // Frame 2 and part of frame 3: varying pixel, pattern mode requested.
    while (mrun < 77199) tick(1'b1, 8'($urandom), 1'b1);

    // Reset mid-line at h=400, v=20 of frame 3.
    tick(1'b0, 8'hCE, 1'b0);
    rmid = cyc;
    want(rmid, S_H, 0);
    want(rmid, S_V, 0);
    want(rmid, S_FS, 0);
    want(rmid, S_HS, 1);
    want(rmid, S_VS, 1);
    want(rmid, S_PX, 8'h00);
    repeat (3) tick(1'b0, 8'hCE, 1'b0);
    tick(1'b1, 8'hCE, 1'b0);
    rel1 = cyc;
    want(rel1 + 1, S_H, 1);
    want(rel1 + 1, S_V, 0);
    repeat (900) tick(1'b1, 8'hCE, 1'b0);

    @(negedge clk_25);
    #1;
    // Spot values whose cycle never came up count as failures.
    for (int i = 0; i < dq.size(); i++) begin
      n_chk++;
      $display("FAIL spot %s never reached cyc=%0d want %0h", sname(dq[i].sel), dq[i].at, dq[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator and output stage for the 640x480@60 Hz VGA path on the Nexys3. It produces the free-running `h_count`/`v_count` coordinates that the drawing stage consumes. It then takes that stage's 8-bit RGB332 pixel back, blanks it outside the visible window and drives the board's VGA pins. Sync and blank are delayed so they stay aligned with the drawing stage's pipeline latency.

## Interface
Parameters:
- `PIPE_DELAY`, default 1: clock cycles between a count value leaving this block and the matching `rgb_in` arriving. Legal range 0..4.
- `H_TOTAL`, default 800: pixel clocks per line.
- `V_TOTAL`, default 525: lines per frame.

Ports:
- `clk_25`, in, 1: 25 MHz pixel clock. Single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `h_count`, out, 10: current column, 0..H_TOTAL-1. Registered.
- `v_count`, out, 10: current line, 0..V_TOTAL-1. Registered.
- `frame_start`, out, 1: one-cycle pulse while `h_count==0 && v_count==0`.
- `rgb_in`, in, 8: RGB332 pixel from the drawing stage, laid out as R[7:5], G[4:2], B[1:0].
- `test_mode`, in, 1: selects the internal colour-bar pattern. Functional only with the macro below.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `vga_red`, out, 3: red component to the pins.
- `vga_green`, out, 3: green component to the pins.
- `vga_blue`, out, 2: blue component to the pins.

## Operation
Horizontal counter:
- `h_count` increments every clock and wraps from 799 to 0.
- Segments: sync 0..95, back porch 96..143, visible 144..783, front porch 784..799.

Vertical counter:
- `v_count` increments only on the cycle where `h_count` wraps 799→0. It wraps from 524 to 0 on that same cycle.
- Segments: sync 0..1, back porch 2..34, visible 35..514, front porch 515..524.

Derived signals, computed combinationally from the current counts:
- `hs_raw = !(h_count<96)`
- `vs_raw = !(v_count<2)`
- `vis_raw = (144<=h_count<784) && (35<=v_count<515)`

Delay line:
- `hs_raw`, `vs_raw` and `vis_raw` pass through a `PIPE_DELAY`-deep shift register. With `PIPE_DELAY`=0 there is no stage.

Output register (one stage, every clock):
- `hsync`/`vsync` take the delayed `hs`/`vs`.
- `{vga_red,vga_green,vga_blue}` take the selected pixel when delayed `vis`=1, otherwise 0.

`frame_start` is registered alongside the counts, so it is high exactly for the cycle in which the outputs read (0,0).

## Timing
Reset (asynchronous assert, synchronous-to-clock release):
- `h_count`=0, `v_count`=0, `frame_start`=0.
- `hsync`=1, `vsync`=1, RGB pins=0.
- All delay-line stages clear to the inactive values `hs`=1, `vs`=1, `vis`=0.

Latency:
- Pin outputs trail the count they describe by exactly `PIPE_DELAY`+1 cycles.
- `rgb_in` sampled at cycle t corresponds to the count presented at t-`PIPE_DELAY`.

Line and frame periods:
- Line period is 800 clocks. Frame period is 420000 clocks.
- `hsync` is low for 96 consecutive clocks per line.
- `vsync` is low for 1600 consecutive clocks per frame, with its edges coincident with `hsync` falling edges.

Reset behaviour:
- Releasing reset starts counting from (0,0) on the first clock edge.
- Reset asserted mid-line forces all of the above values immediately. No partial line completes.

No handshake: `rgb_in` is sampled unconditionally every cycle.

## Configuration
Macro `VGA_TEST_PATTERN_EN`.

Defined:
- When `test_mode`=1, the pixel source is an internal pattern: 8 vertical bars, each 80 px wide across the visible columns.
- Bar index k = (h_count-144)/80, colour = {3{k[2]},3{k[1]},2{k[0]}]. Bar 0 is black, bar 7 is white.
- k travels through the same `PIPE_DELAY` line as `vis`, so bar edges align exactly with the blanking edges.
- When `test_mode`=0, `rgb_in` is used.

Undefined:
- No pattern logic is built. `test_mode` is ignored and `rgb_in` is always used.

## Test plan
- Reset held for 5 clocks, then released → all outputs at reset values during reset; `h_count` reads 1 one clock after release.
- Run 800 clocks after reset → `h_count` wraps to 0, `v_count`=1; with `PIPE_DELAY`=1, `hsync` is low for cycles 2..97.
- Run 420000 clocks → exactly one `frame_start` per frame; `vsync` low for 1600 clocks; `v_count` wraps 524→0 with `h_count`=0.
- Hold `rgb_in`=8'hCE with `PIPE_DELAY`=2 → pins read R=6, G=3, B=2 only for visible pixels; the first non-zero pixel appears 3 clocks after `h_count`=144 on line 35; pins are 0 at v=515.
- Build with `VGA_TEST_PATTERN_EN`, `test_mode`=1 → pixel x=0..79 is black, x=80 is 8'h03, x=560..639 is 8'hFF, with edges aligned to the blanking edges.
- Assert `rst_n` low at `h_count`=400, `v_count`=200 → outputs return to reset values asynchronously; counting restarts at 0 after release.
